// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Decoder reads operands and renames rd; ROB commits write data and retire tags.
module reg_file #(
    parameter int ROB_ID_BITS = 3,
    parameter int DATA_BITS   = 32,
    parameter int REG_NUM     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   rollback,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_rd,
    input  logic [ROB_ID_BITS-1:0] issue_rob_id,
    input  logic [4:0]             rs1_id,
    output logic [DATA_BITS-1:0]   rs1_val,
    output logic                   rs1_busy,
    output logic [ROB_ID_BITS-1:0] rs1_rob_id,
    input  logic [4:0]             rs2_id,
    output logic [DATA_BITS-1:0]   rs2_val,
    output logic                   rs2_busy,
    output logic [ROB_ID_BITS-1:0] rs2_rob_id,
    input  logic                   commit_valid,
    input  logic [4:0]             commit_rd,
    input  logic [DATA_BITS-1:0]   commit_data,
    input  logic [ROB_ID_BITS-1:0] commit_rob_id
);

    logic [DATA_BITS-1:0]   data_q [REG_NUM];
    logic [ROB_ID_BITS-1:0] tag_q  [REG_NUM];
    logic [REG_NUM-1:0]     busy_q;

    logic commit_wr;
    logic commit_hit;
    logic issue_wr;
    logic fwd1;
    logic fwd2;

    assign commit_wr  = commit_valid && (commit_rd != 5'd0);
    // Commit retires the tag only if it is still the youngest producer.
    assign commit_hit = commit_wr && busy_q[commit_rd]
                        && (tag_q[commit_rd] == commit_rob_id);
    assign issue_wr   = issue_valid && (issue_rd != 5'd0) && !rollback;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (rdy) begin
            if (commit_wr) begin
                data_q[commit_rd] <= commit_data;
            end
            if (commit_hit) begin
                busy_q[commit_rd] <= 1'b0;
            end
            // Later assignments win: rollback over all, issue over commit.
            if (rollback) begin
                busy_q <= '0;
            end else if (issue_wr) begin
                busy_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]  <= issue_rob_id;
            end
        end
    end

    assign fwd1 = commit_hit && (commit_rd == rs1_id);
    assign fwd2 = commit_hit && (commit_rd == rs2_id);

    always_comb begin
        rs1_val    = '0;
        rs1_busy   = 1'b0;
        rs1_rob_id = '0;
        if (rs1_id != 5'd0) begin
            rs1_val    = fwd1 ? commit_data : data_q[rs1_id];
            rs1_busy   = busy_q[rs1_id] && !fwd1;
            rs1_rob_id = tag_q[rs1_id];
        end
    end

    always_comb begin
        rs2_val    = '0;
        rs2_busy   = 1'b0;
        rs2_rob_id = '0;
        if (rs2_id != 5'd0) begin
            rs2_val    = fwd2 ? commit_data : data_q[rs2_id];
            rs2_busy   = busy_q[rs2_id] && !fwd2;
            rs2_rob_id = tag_q[rs2_id];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus
// randomized traffic checked against a behavioural model.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_rob_id;
    logic [4:0]  rs1_id;
    logic [31:0] rs1_val;
    logic        rs1_busy;
    logic [2:0]  rs1_rob_id;
    logic [4:0]  rs2_id;
    logic [31:0] rs2_val;
    logic        rs2_busy;
    logic [2:0]  rs2_rob_id;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [2:0]  commit_rob_id;

    int n_cmp;
    int n_err;

    logic [31:0] m_data [32];
    logic        m_busy [32];
    logic [2:0]  m_tag  [32];

    reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_rob_id(issue_rob_id),
        .rs1_id(rs1_id), .rs1_val(rs1_val), .rs1_busy(rs1_busy),
        .rs1_rob_id(rs1_rob_id),
        .rs2_id(rs2_id), .rs2_val(rs2_val), .rs2_busy(rs2_busy),
        .rs2_rob_id(rs2_rob_id),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_rob_id(commit_rob_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_data[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    // Expected operand read for register r under current inputs.
    task automatic model_read(input logic [4:0] r, output logic [31:0] v,
                              output logic b, output logic [2:0] t);
        bit hit;
        v = '0; b = 1'b0; t = '0;
        if (r != 0) begin
            hit = commit_valid && commit_rd == r && m_busy[r]
                  && m_tag[r] == commit_rob_id;
            v = hit ? commit_data : m_data[r];
            b = m_busy[r] && !hit;
            t = m_tag[r];
        end
    endtask

    task automatic check_reads();
        logic [31:0] v;
        logic        b;
        logic [2:0]  t;
        model_read(rs1_id, v, b, t);
        chk("rs1_val", rs1_val, v);
        chk("rs1_busy", 32'(rs1_busy), 32'(b));
        if (b || rs1_id == 0) chk("rs1_tag", 32'(rs1_rob_id), 32'(t));
        model_read(rs2_id, v, b, t);
        chk("rs2_val", rs2_val, v);
        chk("rs2_busy", 32'(rs2_busy), 32'(b));
        if (b || rs2_id == 0) chk("rs2_tag", 32'(rs2_rob_id), 32'(t));
    endtask

    task automatic model_clock();
        if (!rdy) return;
        if (commit_valid && commit_rd != 0) begin
            if (m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_id)
                m_busy[commit_rd] = 1'b0;
            m_data[commit_rd] = commit_data;
        end
        if (rollback) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (issue_valid && issue_rd != 0) begin
            m_busy[issue_rd] = 1'b1;
            m_tag[issue_rd]  = issue_rob_id;
        end
    endtask

    // Called at negedge with inputs set: check reads, advance one clock.
    task automatic step();
        #1;
        check_reads();
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        rdy = 1'b1; rollback = 1'b0;
        issue_valid = 1'b0; commit_valid = 1'b0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [2:0] id);
        idle();
        issue_valid = 1'b1; issue_rd = rd; issue_rob_id = id;
        step();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; idle();
        issue_rd = '0; issue_rob_id = '0;
        commit_rd = '0; commit_data = '0; commit_rob_id = '0;
        rs1_id = '0; rs2_id = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-operation with x5 busy.
        do_issue(5'd5, 3'd2);
        idle(); rs1_id = 5'd5;
        #1 chk("x5_busy_pre", 32'(rs1_busy), 32'd1);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_busy", 32'(rs1_busy), 32'd0);
        chk("rst_val", rs1_val, 32'd0);
        chk("rst_tag", 32'(rs1_rob_id), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // x0 ignores writes.
        idle(); commit_valid = 1'b1; commit_rd = 5'd0;
        commit_data = 32'hDEADBEEF; rs1_id = 5'd0;
        step();
        idle();
        step();
        chk("x0_val", rs1_val, 32'd0);

        // Rename then commit with forwarding.
        do_issue(5'd5, 3'd3);
        idle(); rs1_id = 5'd5;
        #1 chk("ren_busy", 32'(rs1_busy), 32'd1);
        chk("ren_tag", 32'(rs1_rob_id), 32'd3);
        commit_valid = 1'b1; commit_rd = 5'd5;
        commit_rob_id = 3'd3; commit_data = 32'h1234;
        #1 chk("fwd_busy", 32'(rs1_busy), 32'd0);
        chk("fwd_val", rs1_val, 32'h1234);
        step();
        idle();
        #1 chk("st_val", rs1_val, 32'h1234);
        chk("st_busy", 32'(rs1_busy), 32'd0);
        step();

        // Stale commit keeps the younger rename.
        do_issue(5'd7, 3'd1);
        do_issue(5'd7, 3'd4);
        idle(); commit_valid = 1'b1; commit_rd = 5'd7;
        commit_rob_id = 3'd1; commit_data = 32'hAA; rs1_id = 5'd7;
        step();
        idle();
        #1 chk("stale_val", rs1_val, 32'hAA);
        chk("stale_busy", 32'(rs1_busy), 32'd1);
        chk("stale_tag", 32'(rs1_rob_id), 32'd4);
        commit_valid = 1'b1; commit_rob_id = 3'd4; commit_data = 32'hBB;
        step();
        idle();
        #1 chk("young_busy", 32'(rs1_busy), 32'd0);
        chk("young_val", rs1_val, 32'hBB);
        step();

        // Same-cycle issue and commit on x9.
        do_issue(5'd9, 3'd2);
        idle(); commit_valid = 1'b1; commit_rd = 5'd9;
        commit_rob_id = 3'd2; commit_data = 32'h55;
        issue_valid = 1'b1; issue_rd = 5'd9; issue_rob_id = 3'd6;
        rs1_id = 5'd9;
        step();
        idle(); commit_valid = 1'b1; commit_rd = 5'd9;
        commit_rob_id = 3'd5; commit_data = 32'h0;
        #1 chk("ic_busy", 32'(rs1_busy), 32'd1);
        chk("ic_tag", 32'(rs1_rob_id), 32'd6);
        idle();
        #1 chk("ic_val", rs1_val, 32'h55);
        step();

        // Rollback with coincident commit and ignored issue.
        do_issue(5'd3, 3'd1);
        do_issue(5'd4, 3'd2);
        do_issue(5'd10, 3'd3);
        idle(); rollback = 1'b1;
        commit_valid = 1'b1; commit_rd = 5'd10;
        commit_rob_id = 3'd7; commit_data = 32'h99;
        issue_valid = 1'b1; issue_rd = 5'd11; issue_rob_id = 3'd5;
        step();
        idle();
        rs1_id = 5'd3; rs2_id = 5'd4;
        #1 chk("rb_x3", 32'(rs1_busy), 32'd0);
        chk("rb_x4", 32'(rs2_busy), 32'd0);
        rs1_id = 5'd10; rs2_id = 5'd11;
        #1 chk("rb_x10_busy", 32'(rs1_busy), 32'd0);
        chk("rb_x10_val", rs1_val, 32'h99);
        chk("rb_x11", 32'(rs2_busy), 32'd0);
        step();

        // rdy=0 freezes state.
        idle(); rdy = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd12; issue_rob_id = 3'd2;
        commit_valid = 1'b1; commit_rd = 5'd13;
        commit_data = 32'hC0FFEE; commit_rob_id = 3'd0;
        rs1_id = 5'd12; rs2_id = 5'd13;
        repeat (3) step();
        #1 chk("rdy0_x12", 32'(rs1_busy), 32'd0);
        chk("rdy0_x13", rs2_val, 32'd0);
        rdy = 1'b1;
        step();
        idle();
        #1 chk("rdy1_x12", 32'(rs1_busy), 32'd1);
        chk("rdy1_x13", rs2_val, 32'hC0FFEE);
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            rdy          = ($urandom_range(0, 9) != 0);
            rollback     = ($urandom_range(0, 19) == 0);
            issue_valid  = $urandom_range(0, 1) == 1;
            issue_rd     = 5'($urandom_range(0, 7));
            issue_rob_id = 3'($urandom);
            commit_valid = $urandom_range(0, 1) == 1;
            commit_rd    = 5'($urandom_range(0, 7));
            commit_data  = $urandom;
            commit_rob_id = $urandom_range(0, 1) == 1 ?
                            m_tag[commit_rd] : 3'($urandom);
            rs1_id = $urandom_range(0, 1) == 1 ? commit_rd
                                               : 5'($urandom_range(0, 7));
            rs2_id = 5'($urandom_range(0, 31));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags. It sits directly downstream of the reorder buffer's commit port and upstream of the decoder's operand fetch.
- Holds x0..x31 and, per register, a busy bit plus the ROB id of the youngest in-flight producer.
- The decoder reads each operand's value or tag, and renames rd on issue. ROB commits write data and retire tags. Rollback discards all in-flight tags.

Parameters:
- ROB_ID_BITS, 3, width of a ROB entry id (ROB_SZ = 8).
- DATA_BITS, 32, register data width.
- REG_NUM, 32, number of architectural registers; register id width is 5.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; when 0 all state holds.
- rollback  in  1  misprediction flush from ROB.
- issue_valid  in  1  decoder issues an instruction this cycle.
- issue_rd  in  5  destination register of the issued instruction.
- issue_rob_id  in  ROB_ID_BITS  ROB entry allocated to the issued instruction.
- rs1_id  in  5  source-1 register queried by decoder.
- rs1_val  out  DATA_BITS  value of rs1 (valid when rs1_busy=0).
- rs1_busy  out  1  rs1 awaits an in-flight producer.
- rs1_rob_id  out  ROB_ID_BITS  producer tag for rs1 (valid when rs1_busy=1).
- rs2_id, rs2_val, rs2_busy, rs2_rob_id: same as rs1, for source 2.
- commit_valid  in  1  ROB commits a register write.
- commit_rd  in  5  committed destination register.
- commit_data  in  DATA_BITS  committed value.
- commit_rob_id  in  ROB_ID_BITS  ROB id of the committing entry.

Behaviour:
- Reset (rst=0, asynchronous):
  - all data registers, busy bits and tags go to 0 immediately, regardless of clk and rdy.
  - all outputs read 0 while reset is held.
- rdy=0: no state change on clk edges; read outputs remain combinational on current state.
- x0:
  - writes and renames targeting x0 are ignored.
  - a query of x0 returns val=0, busy=0, rob_id=0 at all times.
- Commit (rdy=1, commit_valid=1, commit_rd!=0):
  - data[commit_rd] <= commit_data unconditionally; no tag check is made for the data write.
  - busy[commit_rd] clears only if busy=1 and tag[commit_rd]==commit_rob_id. A younger rename keeps the register busy.
- Issue (rdy=1, issue_valid=1, issue_rd!=0, rollback=0): busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_id.
- Issue and commit to the same rd in one cycle:
  - the issue wins for busy and tag; busy stays 1 with the new tag.
  - the data write still happens.
- Rollback (rdy=1, rollback=1):
  - all busy bits clear next edge.
  - a commit presented in the same cycle is still written, because JALR commit and rollback coincide.
  - issue_valid is ignored in that cycle.
  - tags are left stale; they are don't-care while busy=0.
- Read path: combinational, zero latency; reflects state before this cycle's issue. An instruction reading its own rd sees the older mapping.
- Commit forwarding on reads: if commit_valid=1, commit_rd==rsX_id!=0, busy[rsX]=1 and tag[rsX]==commit_rob_id, then:
  - rsX_busy=0;
  - rsX_val=commit_data.
- Otherwise, reads return:
  - rsX_busy=busy[rsX_id];
  - rsX_rob_id=tag[rsX_id];
  - rsX_val=data[rsX_id].
- No wrap-around or full condition exists. Tag reuse is safe because the ROB never reallocates an id before that entry commits.

Test Plan:
- Reset / x0: hold rst=0 mid-operation with x5 busy -> all queries return 0, busy=0 immediately. Then commit rd=0, data=0xDEADBEEF -> x0 still reads 0.
- Rename then commit:
  - issue rd=5, rob_id=3 -> next cycle rs1_id=5 gives busy=1, rob_id=3.
  - commit rd=5, id=3, data=0x1234 -> same cycle rs1 shows busy=0, val=0x1234 (forwarded); next cycle the same from storage.
- Stale commit:
  - issue rd=7 with id=1, then issue rd=7 with id=4.
  - commit rd=7, id=1, data=0xAA -> data=0xAA but busy=1, rob_id=4.
  - then commit id=4, data=0xBB -> busy=0, val=0xBB.
- Same-cycle issue and commit on rd=9:
  - setup: rd=9 busy with tag 2.
  - stimulus: commit id=2, data=0x55 together with issue id=6.
  - required next cycle: busy=1, rob_id=6, data[9]=0x55.
- Rollback:
  - setup: x3, x4 and x10 busy.
  - stimulus: rollback=1 with commit rd=10, data=0x99 and issue_valid=1 for rd=11.
  - required next cycle: all busy=0, x10=0x99, x11 not busy.
- rdy=0: hold issue rd=12 and commit rd=13 for 3 cycles with rdy=0 -> no change to either register. Raise rdy -> both take effect on the next edge.
